// File: rtl/alu_exec_unit.sv
// RV32I/M execute unit. Single-cycle integer ops are registered in one cycle. Multiply and divide
// run on an iterative shift-add / restoring-divide datapath behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int unsigned XLEN  = 32,
  parameter bit          M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned    ShW     = $clog2(XLEN);
  localparam logic [ShW-1:0] CntLast = ShW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
  } alu_fn_e;

  function automatic alu_fn_e base_fn(input logic [2:0] fn3);
    alu_fn_e fn;
    case (fn3)
      3'b000:  fn = OpAdd;
      3'b001:  fn = OpSll;
      3'b010:  fn = OpSlt;
      3'b011:  fn = OpSltu;
      3'b100:  fn = OpXor;
      3'b101:  fn = OpSrl;
      3'b110:  fn = OpOr;
      default: fn = OpAnd;
    endcase
    return fn;
  endfunction

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;
  logic [ShW-1:0]    cnt_q, cnt_d;
  logic [1:0]        m_sel_q, m_sel_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;

  // Decode
  alu_fn_e fn;
  logic    dec_illegal;
  logic    dec_mext;

  always_comb begin
    fn          = OpAdd;
    dec_illegal = 1'b0;
    dec_mext    = 1'b0;
    case (alu_op)
      2'b00: fn = OpAdd;
      2'b01: fn = OpSub;
      2'b10: begin
        if (f7 == 7'b0000001) begin
          if (M_EXT) dec_mext = 1'b1;
          else       dec_illegal = 1'b1;
        end else if (f7 == 7'b0000000) begin
          fn = base_fn(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          fn = OpSub;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          fn = OpSra;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        // I-type: f7 is immediate data except on the shift encodings
        fn = base_fn(f3);
        if (f3 == 3'b001 && f7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      fn = OpSra;
          else if (f7 != 7'b0000000) dec_illegal = 1'b1;
        end
      end
    endcase
  end

  // Single-cycle datapath
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    shamt = op_b[ShW-1:0];
    case (fn)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpSll:   alu_res = op_a << shamt;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OpXor:   alu_res = op_a ^ op_b;
      OpSrl:   alu_res = op_a >> shamt;
      OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
      OpOr:    alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // M-extension operand preparation
  logic            m_is_div, m_a_signed, m_b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, bypass_res;

  always_comb begin
    m_is_div   = f3[2];
    m_a_signed = m_is_div ? ~f3[0] : (f3[1:0] == 2'b01 || f3[1:0] == 2'b10);
    m_b_signed = m_is_div ? ~f3[0] : (f3[1:0] == 2'b01);
    a_neg      = m_a_signed & op_a[XLEN-1];
    b_neg      = m_b_signed & op_b[XLEN-1];
    mag_a      = a_neg ? -op_a : op_a;
    mag_b      = b_neg ? -op_b : op_b;
    div_zero   = m_is_div && (op_b == '0);
    div_ovf    = m_is_div && !f3[0] && (op_a == MinNeg) && (op_b == '1);
    // f3[1] selects remainder over quotient
    if (f3[1]) bypass_res = div_zero ? op_a : '0;
    else       bypass_res = div_zero ? '1 : op_a;
  end

  // Iteration step and final sign correction
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   rem_step, quot_step, quot_fix, rem_fix, mul_res, div_res;

  always_comb begin
    prod_step = mplier_q[0] ? prod_q + mcand_q : prod_q;
    div_shift = {rem_q, quot_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, divisor_q};
    if (!div_diff[XLEN]) begin
      rem_step  = div_diff[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step  = div_shift[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b0};
    end
    prod_fix = neg_q ? -prod_step : prod_step;
    quot_fix = neg_q ? -quot_step : quot_step;
    rem_fix  = rem_neg_q ? -rem_step : rem_step;
    mul_res  = (m_sel_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_res  = m_sel_q[1] ? rem_fix : quot_fix;
  end

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    m_sel_d     = m_sel_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    divisor_d   = divisor_q;

    case (state_q)
      StIdle: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (in_valid && in_ready) begin
          illegal_d = 1'b0;
          if (dec_illegal) begin
            out_valid_d = 1'b1;
            result_d    = '0;
            illegal_d   = 1'b1;
          end else if (dec_mext && (div_zero || div_ovf)) begin
            out_valid_d = 1'b1;
            result_d    = bypass_res;
          end else if (dec_mext) begin
            state_d   = m_is_div ? StDiv : StMul;
            cnt_d     = '0;
            m_sel_d   = f3[1:0];
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            prod_d    = '0;
            mcand_d   = {{XLEN{1'b0}}, mag_a};
            mplier_d  = mag_b;
            rem_d     = '0;
            quot_d    = mag_a;
            divisor_d = mag_b;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
          end
        end
      end
      StMul, StDiv: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        rem_d    = rem_step;
        quot_d   = quot_step;
        cnt_d    = cnt_q + ShW'(1);
        // Last iteration feeds the sign fix-up directly so the result lands this edge
        if (cnt_q == CntLast) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = (state_q == StMul) ? mul_res : div_res;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      m_sel_q     <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      m_sel_q     <= m_sel_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
    end
  end

endmodule
